// File: rtl/inv_polarity_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : inv_polarity_arbiter
// Description : Registered WIDTH-lane programmable inverter shared by NREQ
//               configuration requesters. A round-robin arbiter accepts one
//               polarity-mask request at a time. When the accepted mask
//               differs from the applied one, the output word is frozen for
//               SETTLE cycles so downstream logic never sees a word built
//               from a mix of old and new lane polarities.
// Ports       : CK     - rising-edge clock
//               LSR    - synchronous active-high reset
//               REQ    - per-requester request level   [NREQ]
//               MASK   - packed requester masks, requester i on
//                        [i*WIDTH +: WIDTH]; 1 = invert lane
//               GNT    - one-hot single-cycle acknowledge [NREQ]
//               A      - lane data in                   [WIDTH]
//               Z      - registered lane data out       [WIDTH]
//               POL    - currently applied polarity     [WIDTH]
//               BLANK  - Z is being held while settling
//               BUSY   - controller is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module inv_polarity_arbiter #(
    parameter int WIDTH  = 8,
    parameter int NREQ   = 4,
    parameter int SETTLE = 3
) (
    input  logic                    CK,
    input  logic                    LSR,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ*WIDTH-1:0]   MASK,
    output logic [NREQ-1:0]         GNT,
    input  logic [WIDTH-1:0]        A,
    output logic [WIDTH-1:0]        Z,
    output logic [WIDTH-1:0]        POL,
    output logic                    BLANK,
    output logic                    BUSY
);

    localparam int c_ptr_w = $clog2(NREQ);
    localparam int c_sum_w = c_ptr_w + 1;

    localparam logic [c_ptr_w-1:0] c_last_req = c_ptr_w'(NREQ - 1);
    localparam logic [c_sum_w-1:0] c_nreq     = c_sum_w'(NREQ);
    localparam logic [3:0]         c_cnt_init = 4'(SETTLE - 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_hold = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_ptr_w-1:0]  r_ptr;
    logic [3:0]          r_cnt;
    logic [WIDTH-1:0]    r_pol;
    logic [WIDTH-1:0]    r_z;
    logic [NREQ-1:0]     r_gnt;

    logic                w_found;
    logic [c_ptr_w-1:0]  w_win;
    logic [c_sum_w-1:0]  w_sum;
    logic [c_ptr_w-1:0]  w_cand;
    logic [WIDTH-1:0]    w_win_mask;
    logic                w_accept;
    logic                w_change;
    logic                w_z_load;
    logic [c_ptr_w-1:0]  w_ptr_nxt;

    // ------------------------------------------------------------------
    // Round-robin search: first set REQ bit at ptr, ptr+1, ... mod NREQ.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + c_sum_w'(k);
            if (w_sum >= c_nreq) begin
                w_sum = w_sum - c_nreq;
            end
            w_cand = w_sum[c_ptr_w-1:0];
            if (!w_found && REQ[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_win_mask = MASK[int'(w_win)*WIDTH +: WIDTH];
    assign w_accept   = (r_state == c_st_idle) && w_found;
    assign w_change   = w_accept && (w_win_mask != r_pol);
    assign w_ptr_nxt  = (w_win == c_last_req) ? '0 : (w_win + 1'b1);

    // The final hold edge (cnt==0) already loads Z with the new polarity, so
    // the last old-polarity word is visible for exactly SETTLE cycles and the
    // first new-polarity word lands on the edge where BLANK drops.
    assign w_z_load   = (r_state == c_st_idle) || (r_cnt == 4'd0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (LSR) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_change) begin
                    w_state_nxt = c_st_hold;
                end
            end
            c_st_hold: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        BLANK = 1'b0;
        BUSY  = 1'b0;
        if (r_state == c_st_hold) begin
            BLANK = 1'b1;
            BUSY  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Arbiter pointer, grant pulse, polarity, settle counter, datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (LSR) begin
            r_ptr <= '0;
            r_gnt <= '0;
            r_pol <= '0;
            r_cnt <= '0;
            r_z   <= '0;
        end else begin
            r_gnt <= '0;
            if (w_accept) begin
                r_gnt[w_win] <= 1'b1;
                r_ptr        <= w_ptr_nxt;
            end

            if (w_change) begin
                r_pol <= w_win_mask;
                r_cnt <= c_cnt_init;
            end else if ((r_state == c_st_hold) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Uses the polarity applied before this edge; a mask accepted on
            // this same edge only takes effect after blanking.
            if (w_z_load) begin
                r_z <= A ^ r_pol;
            end
        end
    end

    assign GNT = r_gnt;
    assign POL = r_pol;
    assign Z   = r_z;

endmodule
`default_nettype wire

// File: tb/tb_inv_polarity_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_polarity_arbiter
// Description : Self-checking bench for inv_polarity_arbiter (WIDTH=8,
//               NREQ=4, SETTLE=3). Directed stimulus pushes expected state
//               and grant records into queues; a monitor on the falling
//               clock edge pops and compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_polarity_arbiter;

    logic        CK = 1'b0;
    logic        LSR;
    logic [3:0]  REQ;
    logic [31:0] MASK;
    logic [3:0]  GNT;
    logic [7:0]  A;
    logic [7:0]  Z;
    logic [7:0]  POL;
    logic        BLANK;
    logic        BUSY;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic prev_blank = 1'b0;

    typedef struct {
        int         cyc;
        logic [7:0] z;
        logic [7:0] pol;
        logic       blank;
        logic [3:0] g;
    } st_t;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [7:0] pol;
    } gn_t;

    st_t sq[$];
    gn_t gq[$];

    inv_polarity_arbiter #(.WIDTH(8), .NREQ(4), .SETTLE(3)) dut (
        .CK    (CK),
        .LSR   (LSR),
        .REQ   (REQ),
        .MASK  (MASK),
        .GNT   (GNT),
        .A     (A),
        .Z     (Z),
        .POL   (POL),
        .BLANK (BLANK),
        .BUSY  (BUSY)
    );

    always #5 CK = ~CK;

    always @(posedge CK) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge CK) begin : mon
        st_t e;
        gn_t g;
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            e = sq.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc || Z !== e.z || POL !== e.pol || BLANK !== e.blank
                || BUSY !== e.blank || GNT !== e.g) begin
                errors = errors + 1;
                $display("FAIL state@%0d: got Z=%h POL=%h BLANK=%b BUSY=%b GNT=%b, want Z=%h POL=%h BLANK=%b BUSY=%b GNT=%b (cyc %0d)",
                         e.cyc, Z, POL, BLANK, BUSY, GNT, e.z, e.pol, e.blank, e.blank, e.g, cyc);
            end
        end
        while (gq.size() > 0 && gq[0].cyc < cyc) begin
            g = gq.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL gnt_missing@%0d: got no GNT, want GNT=%b", g.cyc, g.g);
        end
        if (GNT != 4'b0) begin
            checks = checks + 1;
            if (!$onehot(GNT) || prev_blank) begin
                errors = errors + 1;
                $display("FAIL gnt_shape@%0d: got GNT=%b prev_blank=%b, want one-hot outside HOLD",
                         cyc, GNT, prev_blank);
            end
            checks = checks + 1;
            if (gq.size() == 0 || gq[0].cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL gnt_unexpected@%0d: got GNT=%b, want no grant", cyc, GNT);
            end else begin
                g = gq.pop_front();
                if (GNT !== g.g || POL !== g.pol) begin
                    errors = errors + 1;
                    $display("FAIL gnt@%0d: got GNT=%b POL=%h, want GNT=%b POL=%h",
                             cyc, GNT, POL, g.g, g.pol);
                end
            end
        end
        prev_blank <= BLANK;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic exp_st(input logic [7:0] z, input logic [7:0] pol,
                          input logic b, input logic [3:0] g);
        st_t e;
        e.cyc = cyc; e.z = z; e.pol = pol; e.blank = b; e.g = g;
        sq.push_back(e);
    endtask

    task automatic exp_g(input int c, input logic [3:0] g, input logic [7:0] pol);
        gn_t e;
        e.cyc = c; e.g = g; e.pol = pol;
        gq.push_back(e);
    endtask

    task automatic set_mask(input int i, input logic [7:0] m);
        MASK[i*8 +: 8] = m;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int c0;
        int e0;
        int f0;
        LSR  = 1'b1;
        REQ  = 4'b0;
        MASK = 32'h0;
        A    = 8'hA5;

        // Reset, then idle tracking
        tick(); exp_st(8'h00, 8'h00, 1'b0, 4'b0000);
        tick(); exp_st(8'h00, 8'h00, 1'b0, 4'b0000);
        LSR = 1'b0;
        tick(); exp_st(8'hA5, 8'h00, 1'b0, 4'b0000);

        // Single polarity change from requester 1
        A = 8'h3C; REQ = 4'b0010; set_mask(1, 8'h0F);
        exp_g(cyc + 1, 4'b0010, 8'h0F);
        tick(); exp_st(8'h3C, 8'h0F, 1'b1, 4'b0010);
        REQ = 4'b0;
        tick(); exp_st(8'h3C, 8'h0F, 1'b1, 4'b0000);
        tick(); exp_st(8'h3C, 8'h0F, 1'b1, 4'b0000);
        tick(); exp_st(8'h33, 8'h0F, 1'b0, 4'b0000);

        // Same-mask request: grant, no blanking, pointer moves to 3
        REQ = 4'b0100; set_mask(2, 8'h0F); A = 8'h11;
        exp_g(cyc + 1, 4'b0100, 8'h0F);
        tick(); exp_st(8'h1E, 8'h0F, 1'b0, 4'b0100);
        REQ = 4'b0; A = 8'h22;
        tick(); exp_st(8'h2D, 8'h0F, 1'b0, 4'b0000);

        // Reset to bring the pointer back to 0
        LSR = 1'b1;
        tick(); exp_st(8'h00, 8'h00, 1'b0, 4'b0000);
        LSR = 1'b0;

        // Round robin with all four requesting, alternating masks
        set_mask(0, 8'hFF); set_mask(1, 8'h00); set_mask(2, 8'hFF); set_mask(3, 8'h00);
        A = 8'h5A; REQ = 4'b1111;
        c0 = cyc + 1;
        exp_g(c0,      4'b0001, 8'hFF);
        exp_g(c0 + 4,  4'b0010, 8'h00);
        exp_g(c0 + 8,  4'b0100, 8'hFF);
        exp_g(c0 + 12, 4'b1000, 8'h00);
        tick(); exp_st(8'h5A, 8'hFF, 1'b1, 4'b0001);
        REQ[0] = 1'b0;
        while (cyc < c0 + 3) tick();
        exp_st(8'hA5, 8'hFF, 1'b0, 4'b0000);
        for (int i = 1; i < 4; i++) begin
            while (cyc < c0 + 4*i) tick();
            REQ[i] = 1'b0;
        end
        while (cyc < c0 + 15) tick();
        exp_st(8'h5A, 8'h00, 1'b0, 4'b0000);

        // Reset during the second blanking cycle, REQ[3] still held
        REQ = 4'b1000; set_mask(3, 8'hF0); A = 8'h12;
        e0 = cyc + 1;
        exp_g(e0, 4'b1000, 8'hF0);
        tick(); exp_st(8'h12, 8'hF0, 1'b1, 4'b1000);
        tick();
        LSR = 1'b1;
        tick(); exp_st(8'h00, 8'h00, 1'b0, 4'b0000);
        LSR = 1'b0;
        exp_g(e0 + 3, 4'b1000, 8'hF0);
        tick(); exp_st(8'h12, 8'hF0, 1'b1, 4'b1000);
        REQ = 4'b0;
        while (cyc < e0 + 6) tick();
        exp_st(8'hE2, 8'hF0, 1'b0, 4'b0000);

        // Request raised during HOLD waits for IDLE; A changes while held
        REQ = 4'b0100; set_mask(2, 8'h0F); A = 8'h30;
        f0 = cyc + 1;
        exp_g(f0, 4'b0100, 8'h0F);
        tick(); exp_st(8'hC0, 8'h0F, 1'b1, 4'b0100);
        REQ = 4'b0001; set_mask(0, 8'hAA); A = 8'h77;
        exp_g(f0 + 4, 4'b0001, 8'hAA);
        tick(); exp_st(8'hC0, 8'h0F, 1'b1, 4'b0000);
        tick(); exp_st(8'hC0, 8'h0F, 1'b1, 4'b0000);
        tick(); exp_st(8'h78, 8'h0F, 1'b0, 4'b0000);
        tick(); exp_st(8'h78, 8'hAA, 1'b1, 4'b0001);
        REQ = 4'b0;
        while (cyc < f0 + 7) tick();
        exp_st(8'hDD, 8'hAA, 1'b0, 4'b0000);

        // Drain and confirm every expectation was consumed
        tick(); tick(); tick();
        checks = checks + 1;
        if (sq.size() != 0) begin
            errors = errors + 1;
            $display("FAIL state_queue: got %0d pending, want 0", sq.size());
        end
        checks = checks + 1;
        if (gq.size() != 0) begin
            errors = errors + 1;
            $display("FAIL gnt_queue: got %0d pending, want 0", gq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
